// File: rtl/branch_target_buffer_if.sv
// Fetch-side bundle of the branch target buffer: lookup (pc -> prediction)
// and the one-cycle training port from the ID-stage control unit.
interface branch_target_buffer_if #(
    parameter int WORD_SIZE = 16
) ();
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pred_pc;
    logic                 pred_taken;
    logic                 upd_valid;
    logic [WORD_SIZE-1:0] upd_pc;
    logic [WORD_SIZE-1:0] upd_target;
    logic                 upd_taken;
    logic                 upd_mispred;
    logic [15:0]          mispred_cnt;

    modport master (
        output pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
        input  pred_pc, pred_taken, mispred_cnt
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
        output pred_pc, pred_taken, mispred_cnt
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with combinational lookup and registered training.
// Define BTB_2BIT_COUNTER_EN for per-entry 2-bit direction counters; otherwise any hit predicts taken.
module branch_target_buffer #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_target_buffer_if.slave btb
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [TAG_W-1:0]     tag_d    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [WORD_SIZE-1:0] target_d [ENTRIES];
    logic [15:0]          mispred_cnt_q, mispred_cnt_d;
`ifdef BTB_2BIT_COUNTER_EN
    logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
`endif

    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]      rd_tag, wr_tag;
    logic                  rd_hit, wr_hit, rd_taken;

    always_comb begin
        rd_idx = btb.pc[INDEX_BITS-1:0];
        rd_tag = btb.pc[WORD_SIZE-1:INDEX_BITS];
        rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
`ifdef BTB_2BIT_COUNTER_EN
        rd_taken = rd_hit && ctr_q[rd_idx][1];
`else
        rd_taken = rd_hit;
`endif
    end

    // Reset forces a miss even though the arrays still hold stale entries.
    assign btb.pred_taken  = reset_n && rd_taken;
    assign btb.pred_pc     = btb.pred_taken ? target_q[rd_idx] : btb.pc + WORD_SIZE'(1);
    assign btb.mispred_cnt = mispred_cnt_q;

    always_comb begin
        wr_idx        = btb.upd_pc[INDEX_BITS-1:0];
        wr_tag        = btb.upd_pc[WORD_SIZE-1:INDEX_BITS];
        wr_hit        = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        valid_d       = valid_q;
        tag_d         = tag_q;
        target_d      = target_q;
        mispred_cnt_d = mispred_cnt_q;
`ifdef BTB_2BIT_COUNTER_EN
        ctr_d         = ctr_q;
`endif
        if (btb.upd_valid) begin
            if (btb.upd_taken) begin
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = btb.upd_target;
`ifdef BTB_2BIT_COUNTER_EN
                if (!wr_hit)
                    ctr_d[wr_idx] = 2'b10;
                else if (ctr_q[wr_idx] != 2'b11)
                    ctr_d[wr_idx] = ctr_q[wr_idx] + 2'd1;
`endif
            end else if (wr_hit) begin
`ifdef BTB_2BIT_COUNTER_EN
                if (ctr_q[wr_idx] != 2'b00)
                    ctr_d[wr_idx] = ctr_q[wr_idx] - 2'd1;
`else
                valid_d[wr_idx] = 1'b0;
`endif
            end
            if (btb.upd_mispred && (mispred_cnt_q != '1))
                mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    // Tag and target arrays are left unreset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q       <= '0;
            mispred_cnt_q <= '0;
`ifdef BTB_2BIT_COUNTER_EN
            ctr_q         <= {ENTRIES{2'b01}};
`endif
        end else begin
            valid_q       <= valid_d;
            mispred_cnt_q <= mispred_cnt_d;
`ifdef BTB_2BIT_COUNTER_EN
            ctr_q         <= ctr_d;
`endif
        end
        tag_q    <= tag_d;
        target_q <= target_d;
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: vector table plus counter-wrap sequence,
// expectations queued at drive time and compared at the falling edge.
module tb_branch_target_buffer;
    typedef struct {
        logic        rst_n;
        logic [15:0] pc;
        logic        uv;
        logic [15:0] upc;
        logic [15:0] utgt;
        logic        ut;
        logic        um;
        logic        exp_taken;
        logic [15:0] exp_pc;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        int          id;
        logic        taken;
        logic [15:0] pc;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    branch_target_buffer_if #(.WORD_SIZE(16)) bus ();

    branch_target_buffer #(.WORD_SIZE(16), .INDEX_BITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btb     (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(int id, string what, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row%0d %s actual=%h expected=%h", id, what, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.id, "pred_taken", {15'd0, bus.pred_taken}, {15'd0, e.taken});
            chk(e.id, "pred_pc", bus.pred_pc, e.pc);
            chk(e.id, "mispred_cnt", bus.mispred_cnt, e.cnt);
        end
    end

    function automatic void add(logic rst_n, logic [15:0] pc, logic uv, logic [15:0] upc,
                                logic [15:0] utgt, logic ut, logic um,
                                logic et, logic [15:0] epc, logic [15:0] ecnt);
        vec_t v;
        v.rst_n = rst_n; v.pc = pc; v.uv = uv; v.upc = upc; v.utgt = utgt;
        v.ut = ut; v.um = um; v.exp_taken = et; v.exp_pc = epc; v.exp_cnt = ecnt;
        vecs.push_back(v);
    endfunction

    // Called just after a rising edge; returns on the next rising edge.
    task automatic step(input vec_t v, input int id);
        exp_t e;
        #1;
        reset_n         = v.rst_n;
        bus.pc          = v.pc;
        bus.upd_valid   = v.uv;
        bus.upd_pc      = v.upc;
        bus.upd_target  = v.utgt;
        bus.upd_taken   = v.ut;
        bus.upd_mispred = v.um;
        e.id = id; e.taken = v.exp_taken; e.pc = v.exp_pc; e.cnt = v.exp_cnt;
        sb.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        vec_t v;
        //  rst  pc       uv  upc      tgt      t  m    et  exp_pc   cnt
        add(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0011, 16'd0);  // 0 cold
        add(1, 16'h0012, 1, 16'h0012, 16'h0040, 1, 1,   0, 16'h0013, 16'd0);  // 1 allocate
        add(1, 16'h0012, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0040, 16'd1);  // 2 hit
        add(1, 16'h0022, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0023, 16'd1);  // 3 tag miss
        add(1, 16'h0012, 1, 16'h0012, 16'h0040, 1, 0,   1, 16'h0040, 16'd1);  // 4 taken
        add(1, 16'h0012, 1, 16'h0012, 16'h0000, 0, 0,   1, 16'h0040, 16'd1);  // 5 not taken
`ifdef BTB_2BIT_COUNTER_EN
        add(1, 16'h0012, 1, 16'h0012, 16'h0000, 0, 0,   1, 16'h0040, 16'd1);  // 6 ctr=2
        add(1, 16'h0012, 1, 16'h0012, 16'h0000, 0, 0,   0, 16'h0013, 16'd1);  // 7 ctr=1
        add(1, 16'h0012, 1, 16'h0012, 16'h0000, 0, 0,   0, 16'h0013, 16'd1);  // 8 ctr=0, stays 0
        add(1, 16'h0012, 1, 16'h0012, 16'h0050, 1, 0,   0, 16'h0013, 16'd1);  // 9 0->1
        add(1, 16'h0012, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0013, 16'd1);  // 10 still weak NT
`else
        add(1, 16'h0012, 1, 16'h0012, 16'h0000, 0, 0,   0, 16'h0013, 16'd1);  // 6 invalidated
        add(1, 16'h0012, 1, 16'h0012, 16'h0000, 0, 0,   0, 16'h0013, 16'd1);  // 7
        add(1, 16'h0012, 1, 16'h0012, 16'h0000, 0, 0,   0, 16'h0013, 16'd1);  // 8
        add(1, 16'h0012, 1, 16'h0012, 16'h0050, 1, 0,   0, 16'h0013, 16'd1);  // 9 realloc
        add(1, 16'h0012, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0050, 16'd1);  // 10
`endif
        add(1, 16'h0003, 1, 16'h0003, 16'h0100, 1, 0,   0, 16'h0004, 16'd1);  // 11 same-cycle alloc
        add(1, 16'h0003, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0100, 16'd1);  // 12
        add(1, 16'h0003, 1, 16'h0003, 16'h0200, 1, 0,   1, 16'h0100, 16'd1);  // 13 old target
        add(1, 16'h0003, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0200, 16'd1);  // 14 new target
        add(1, 16'h0003, 1, 16'h0005, 16'h0300, 1, 0,   1, 16'h0200, 16'd1);  // 15 other index
        add(1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0300, 16'd1);  // 16
        add(1, 16'h0003, 0, 16'h0000, 16'h0000, 0, 1,   1, 16'h0200, 16'd1);  // 17 mispred w/o valid
        add(1, 16'h0003, 0, 16'h0000, 16'h0000, 0, 0,   1, 16'h0200, 16'd1);  // 18 not counted
        add(1, 16'h0003, 1, 16'h0077, 16'h0000, 0, 1,   1, 16'h0200, 16'd1);  // 19 NT miss
        add(1, 16'h0077, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0078, 16'd2);  // 20 no alloc
        add(1, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0000, 16'd2);  // 21 pc wrap
        add(0, 16'h0003, 1, 16'h0003, 16'h0400, 1, 1,   0, 16'h0004, 16'd2);  // 22 reset forces miss
        add(1, 16'h0003, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0004, 16'd0);  // 23 reset won
        add(1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 0,   0, 16'h0006, 16'd0);  // 24 all cleared

        reset_n = 1'b0;
        bus.pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
        bus.upd_taken = 1'b0; bus.upd_mispred = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Bulk-load the mispredict counter to 16'hFFFE with not-taken misses.
        #1;
        bus.pc = 16'h0030; bus.upd_valid = 1'b1; bus.upd_pc = 16'h0077;
        bus.upd_target = '0; bus.upd_taken = 1'b0; bus.upd_mispred = 1'b1;
        repeat (65534) @(posedge clk);

        v.rst_n = 1; v.pc = 16'h0030; v.uv = 1; v.upc = 16'h0077; v.utgt = '0;
        v.ut = 0; v.um = 1; v.exp_taken = 0; v.exp_pc = 16'h0031;
        v.exp_cnt = 16'hFFFE; step(v, 100);
        v.exp_cnt = 16'hFFFF; step(v, 101);
        v.exp_cnt = 16'hFFFF; step(v, 102);
        v.uv = 0; v.exp_cnt = 16'hFFFF; step(v, 103);
        v.um = 0; v.pc = 16'hFFFF; v.exp_pc = 16'h0000; step(v, 104);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
